// File: rtl/tff_count_sequencer.sv
// Modulo-M up/down counter sequencer for a T flip-flop bank, with run/hold/abort handshake.
// Define TFF_SEQ_AUTORELOAD_EN to wrap to init at terminal count instead of stopping in DONE.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_en,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] tEn;
  logic [WIDTH-1:0] lastVal, initVal, loadInit;
  logic [WIDTH-1:0] upMask, dnMask;
  logic             carryUp, carryDn;

  // dir_q=1 counts up from 0 to M-1; dir_q=0 counts down from M-1 to 0 (M=0 means 2^WIDTH).
  assign lastVal  = dir_q ? (mod_q - WIDTH'(1)) : '0;
  assign initVal  = dir_q ? '0 : (mod_q - WIDTH'(1));
  assign loadInit = up_dn ? '0 : (mod_val - WIDTH'(1));

  // Toggle masks: bit i flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    upMask  = '0;
    dnMask  = '0;
    carryUp = 1'b1;
    carryDn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      upMask[i] = carryUp;
      dnMask[i] = carryDn;
      carryUp   = carryUp & count_q[i];
      carryDn   = carryDn & ~count_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    tEn     = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          mod_d   = mod_val;
          dir_d   = up_dn;
          tEn     = count_q ^ loadInit;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (count_q == lastVal) begin
          tc_d = 1'b1;
`ifdef TFF_SEQ_AUTORELOAD_EN
          tEn = count_q ^ initVal;
`else
          state_d = DONE;
`endif
        end else begin
          tEn = dir_q ? upMask : dnMask;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state advances on the falling edge of clk.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mod_q   <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_q ^ tEn;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign t_en  = tEn;
  assign busy  = (state_q == RUN) || (state_q == HOLD);
  assign done  = (state_q == DONE);
  assign tc    = tc_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Scoreboard bench for tff_count_sequencer: stimulus queues expected outputs, a monitor checks them mid-cycle.
module tb_tff_count_sequencer;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       up_dn = 1'b0;
  logic [3:0] mod_val = 4'd0;
  logic [3:0] count;
  logic [3:0] t_en;
  logic       busy;
  logic       done;
  logic       tc;

  typedef struct {
    int         step;
    logic [3:0] cnt;
    logic       bsy;
    logic       dn;
    logic       tcv;
    logic [3:0] ten;
  } exp_t;

  exp_t sbQ[$];
  int   passCount = 0;
  int   checkCount = 0;
  int   stepNo = 0;

  tff_count_sequencer #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .up_dn  (up_dn),
    .mod_val(mod_val),
    .count  (count),
    .t_en   (t_en),
    .busy   (busy),
    .done   (done),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input int step, input logic [3:0] act,
                             input logic [3:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s step %0d: got %0h, expected %0h", nm, step, act, req);
  endtask

  // Monitor samples on the rising edge, half a cycle away from the active falling edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("count", e.step, count, e.cnt);
      checkOutput("busy", e.step, {3'b0, busy}, {3'b0, e.bsy});
      checkOutput("done", e.step, {3'b0, done}, {3'b0, e.dn});
      checkOutput("tc", e.step, {3'b0, tc}, {3'b0, e.tcv});
      checkOutput("t_en", e.step, t_en, e.ten);
    end
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic ud,
                               input logic [3:0] mv, input logic [3:0] eCnt,
                               input logic eBusy, input logic eDone, input logic eTc,
                               input logic [3:0] eTen);
    start   = st;
    stop    = sp;
    up_dn   = ud;
    mod_val = mv;
    stepNo++;
    sbQ.push_back('{stepNo, eCnt, eBusy, eDone, eTc, eTen});
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    @(negedge clk);
    #1;
    doReset();

`ifdef TFF_SEQ_AUTORELOAD_EN
    // Free-running modulo-16 up count: wrap at 15 with full toggle, tc one cycle later.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 15; c++)
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'(c), 1'b1, 1'b0, 1'b0, 4'(c) ^ 4'(c + 1));
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 4'hF);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'h3);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 4'h0);
`else
    // Up count modulo 10, stopping in DONE with count held at 9.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 9; c++)
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd10, 4'(c), 1'b1, 1'b0, 1'b0, 4'(c) ^ 4'(c + 1));
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0);
    // Down count modulo 6 from 9: load 5 (t_en = 9^5), count to 0, DONE for one cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 4'hC);
    for (int c = 5; c > 0; c--)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd6, 4'(c), 1'b1, 1'b0, 1'b0, 4'(c) ^ 4'(c - 1));
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
`endif

    // Pause/resume; up_dn and mod_val wiggle while running and must be ignored.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int c = 0; c < 3; c++)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd2, 4'(c), 1'b1, 1'b0, 1'b0, 4'(c) ^ 4'(c + 1));
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0);

    // Abort from HOLD, then restart down modulo 7: init 6 loaded over retained count 4.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd10, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd10, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 4'd4, 1'b0, 1'b0, 1'b0, 4'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 4'd6, 1'b1, 1'b0, 1'b0, 4'd3);

    // Asynchronous reset mid-run at count 5, observed before the next falling edge.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);

    @(posedge clk);
    #1;
    checkCount++;
    if (sbQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
